uni_reg_wide: RTL
=================

# uni_reg_wide

Parametrised successor of the 8-bit universal register: a WIDTH-bit loadable up/down counter that is written from a narrow BUS-wide data bus one segment at a time. Two tri-state read ports each present any one segment. A per-port snapshot makes multi-segment reads coherent while the counter runs. It serves as the CPU's wide pointer/address register (PC, stack and memory pointers) on the 8-bit internal buses, and also exposes the full value as an address output.

## Interface
Parameters:
- WIDTH, 16, register width; must be a multiple of BUS.
- BUS, 8, data bus width; NSEG = WIDTH/BUS segments, segment 0 is least significant.
- SNAP, 1, 1 enables coherent-read snapshots on both read ports, 0 disables them.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- we_n  in  NSEG  active-low per-segment load enable from di.
- cnt  in  1  active-high count enable.
- dir  in  1  count direction: 0 counts up, 1 counts down.
- di  in  BUS  load data.
- oea_n, oeb_n  in  1 each  active-low output enables for doa and dob.
- sela, selb  in  clog2(NSEG), minimum 1  segment select for port A and port B.
- doa, dob  out (tri)  BUS  read ports; high-Z when the matching oe*_n is 1.
- q  out  WIDTH  full register value, always driven.
- rco  out  1  terminal count (carry when counting up, borrow when counting down).

## Operation
- Priority at each edge: rst, then load (any we_n bit low), then count, then hold.
- rst: q <= 0 and both snapshots <= 0.
- Load: each segment i with we_n[i]=0 takes di. Segments with we_n[i]=1 hold. No counting happens in that cycle, even if cnt=1.
- Count (cnt=1, all we_n high):
  - dir=0: q <= q+1, wrapping from all-ones to 0.
  - dir=1: q <= q-1, wrapping from 0 to all-ones.
  - The carry or borrow ripples across all segments within the same cycle.
- rco = cnt & (dir ? q==0 : q==all-ones). It is combinational and independent of we_n. It matches the legacy ripple-carry output, so registers can be cascaded.
- Read path, port A (port B is identical and independent):
  - doa = oea_n ? 'z : seg(sela).
  - With SNAP=0, seg(k) is always the live segment k of q.
  - With SNAP=1, when sela=0 the port returns live segment 0.
  - With SNAP=1, when sela=k>0 the port returns snapshot segment k.
- Snapshot capture (SNAP=1): at any edge where oea_n=0 and sela=0, snapA[WIDTH-1:BUS] <= q[WIDTH-1:BUS]. The captured value is the pre-edge q, i.e. the upper part of the same value that was read on segment 0.
- Snapshot reads: while oea_n=0 and sela>0, snapA holds its value. Snapshots are never updated by load or count.
- Software reads low-first for a coherent pair. A high-segment read without a preceding low read returns the last snapshot, which is 0 after reset.

## Timing
- Load and count latency is 1 cycle: values are visible on q, doa and dob after the edge.
- doa, dob and rco are combinational from registered state and the select/enable inputs, with no extra latency.
- Simultaneous load of segment 0 with cnt=1: load wins and the count is lost.
- Partial load with cnt=1: no segment counts, including the segments that are not loaded.
- Reset wins over a simultaneous load, count or snapshot capture in the same cycle.
- Reading and loading the same segment in one cycle: the port shows the old value and the new value appears next cycle.
- Snapshot capture coinciding with a count edge: the snapshot holds the pre-count upper bits.

## Structure
- Package uni_reg_pkg: DIR_UP=1'b0, DIR_DOWN=1'b1, and a function for the select width, clog2(NSEG) with a minimum of 1.
- Sub-module count_seg: a BUS-wide segment with load, count enable, carry-in and carry-out, mirroring one stage of the 163 chain. The top level instantiates NSEG of them in a generate loop, plus the read muxes, snapshots and tri-state drivers.
- Elaboration error if WIDTH % BUS != 0 or NSEG < 1.

## Test plan
- Reset then load: rst=1 for one cycle gives q=0000. Then we_n=10 with di=34 followed by we_n=01 with di=12 gives q=1234. During the second load cnt=1, and q must not increment.
- Up wrap: q=FFFF with cnt=1, dir=0. rco=1 before the edge, then q=0000 and rco=0.
- Down wrap across a segment: q=0100, dir=1, cnt=1 gives 00FF. Starting from 0000 gives rco=1, then FFFF.
- Coherent read: q=12FF counting up. Read port A sela=0 gives FF (q becomes 1300). Next cycle sela=1 returns 12, not 13. Port B reading sela=1 with no prior low read returns 00 after reset.
- Tri-state and independence: oea_n=1 gives doa=Z while dob=low segment with selb=0. Both ports can select different segments in the same cycle.
- Reset mid-count: running with cnt=1 and rst asserted gives q=0000, rco=0 (when dir=0) and cleared snapshots on the next edge.

Source files
------------

// File: rtl/uni_reg_pkg.sv
// Shared constants and helpers for the wide universal register.
// Both the top level and the per-segment counter import this package.
package uni_reg_pkg;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   // A one-segment register still needs a one-bit select port.
   function automatic int sel_width(input int nseg);
      return (nseg <= 1) ? 1 : $clog2(nseg);
   endfunction

endpackage

// File: rtl/uni_reg_wide_count_seg.sv
// One BUS-wide stage of the ripple counter chain.
// It counts only when every lower stage is at its terminal value.
module count_seg
   import uni_reg_pkg::*;
#(
   parameter int BUS = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ld_i,
   input  logic           hold_i,
   input  logic           dir_i,
   input  logic           ci_i,
   input  logic [BUS-1:0] d_i,
   output logic [BUS-1:0] q_o,
   output logic           co_o
);

   logic [BUS-1:0] q_q, q_d;

   // hold_i is high when any segment loads, which freezes every segment's count.
   always_comb begin
      // NOTE: assign the default first so every path drives q_d and no latch is inferred.
      q_d = q_q;
      if (ld_i) begin
         q_d = d_i;
      end else if (!hold_i && ci_i) begin
         q_d = (dir_i == DIR_DOWN) ? q_q - BUS'(1) : q_q + BUS'(1);
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) q_q <= '0;
      else     q_q <= q_d;
   end

   assign q_o  = q_q;
   assign co_o = ci_i & ((dir_i == DIR_DOWN) ? (q_q == '0) : (q_q == '1));

endmodule

// File: rtl/uni_reg_wide.sv
// WIDTH-bit loadable up/down counter written one BUS-wide segment at a time,
// with two tri-state segment read ports and optional coherent-read snapshots.
module uni_reg_wide
   import uni_reg_pkg::*;
#(
   parameter  int WIDTH = 16,
   parameter  int BUS   = 8,
   parameter  int SNAP  = 1,
   localparam int NSEG  = WIDTH / BUS,
   localparam int SW    = sel_width(WIDTH / BUS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NSEG-1:0]  we_n,
   input  logic             cnt,
   input  logic             dir,
   input  logic [BUS-1:0]   di,
   input  logic             oea_n,
   input  logic             oeb_n,
   input  logic [SW-1:0]    sela,
   input  logic [SW-1:0]    selb,
   output wire  [BUS-1:0]   doa,
   output wire  [BUS-1:0]   dob,
   output logic [WIDTH-1:0] q,
   output logic             rco
);

   if ((WIDTH % BUS) != 0 || (WIDTH / BUS) < 1) begin : g_bad_geometry
      $error("uni_reg_wide: WIDTH must be a non-zero multiple of BUS");
   end

   logic [NSEG:0]      carry;
   logic               any_ld;
   logic [WIDTH-1:0]   view_a, view_b;

   assign any_ld   = ~&we_n;
   assign carry[0] = cnt;

   for (genvar i = 0; i < NSEG; i++) begin : g_seg
      count_seg #(.BUS(BUS)) u_seg (
         .clk    (clk),
         .rst    (rst),
         .ld_i   (~we_n[i]),
         .hold_i (any_ld),
         .dir_i  (dir),
         .ci_i   (carry[i]),
         .d_i    (di),
         .q_o    (q[i*BUS +: BUS]),
         .co_o   (carry[i+1])
      );
   end

   assign rco = carry[NSEG];

   // A read of segment 0 freezes the upper segments so a following high read matches it.
   if (SNAP != 0 && NSEG > 1) begin : g_snap
      logic [WIDTH-1:BUS] snap_a_q, snap_b_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            snap_a_q <= '0;
            snap_b_q <= '0;
         end else begin
            if (!oea_n && sela == '0) snap_a_q <= q[WIDTH-1:BUS];
            if (!oeb_n && selb == '0) snap_b_q <= q[WIDTH-1:BUS];
         end
      end

      assign view_a = {snap_a_q, q[BUS-1:0]};
      assign view_b = {snap_b_q, q[BUS-1:0]};
   end else begin : g_live
      assign view_a = q;
      assign view_b = q;
   end

   assign doa = oea_n ? 'z : view_a[int'(sela)*BUS +: BUS];
   assign dob = oeb_n ? 'z : view_b[int'(selb)*BUS +: BUS];

endmodule
